// File: rtl/i2c_phase_timer.sv
// Phase timer for an I2C bit engine: divides each bit into PHASES phases of Ticks cycles.
// Optional SCL clock-stretch hold on the SCL-high phase is enabled by defining I2C_PHASE_STRETCH_EN.
module i2c_phase_timer #(
  parameter int SIZE   = 8,
  parameter int PHASES = 4
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        Start,
  input  logic                        Stop,
  input  logic [SIZE-1:0]             Ticks,
  input  logic                        Mode,
`ifdef I2C_PHASE_STRETCH_EN
  input  logic                        Stretch,
`endif
  output logic                        Out,
  output logic [$clog2(PHASES)-1:0]   Phase,
  output logic                        BitDone,
  output logic                        Busy
);

  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0]   LAST_PH = PW'(PHASES - 1);
  localparam logic [PW-1:0]   HIGH_PH = PW'(PHASES / 2);
  localparam logic [SIZE-1:0] ONE     = SIZE'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] tk_lat_q, tk_lat_d;
  logic            mode_lat_q, mode_lat_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            out_d, bit_done_d;
  logic            stretch_hold;

`ifdef I2C_PHASE_STRETCH_EN
  // A stretching target holds SCL low; only the SCL-high phase is allowed to wait for it.
  assign stretch_hold = Stretch && (phase_q == HIGH_PH);
`else
  assign stretch_hold = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tk_lat_d   = tk_lat_q;
    mode_lat_d = mode_lat_q;
    phase_d    = phase_q;
    out_d      = 1'b0;
    bit_done_d = 1'b0;

    if (Start) begin
      phase_d = '0;
      if (Ticks != '0) begin
        cnt_d      = Ticks;
        tk_lat_d   = Ticks;
        mode_lat_d = Mode;
        state_d    = RUN;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == RUN && !Stop) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else if (!stretch_hold) begin
        // Terminal count: end of phase, reload and advance.
        out_d   = 1'b1;
        cnt_d   = tk_lat_q;
        phase_d = phase_q + 1'b1;
        if (phase_q == LAST_PH) begin
          bit_done_d = 1'b1;
          if (mode_lat_q) begin
            state_d = IDLE;
            phase_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tk_lat_q   <= '0;
      mode_lat_q <= 1'b0;
      phase_q    <= '0;
      Out        <= 1'b0;
      BitDone    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tk_lat_q   <= tk_lat_d;
      mode_lat_q <= mode_lat_d;
      phase_q    <= phase_d;
      Out        <= out_d;
      BitDone    <= bit_done_d;
    end
  end

  assign Phase = phase_q;
  assign Busy  = (state_q == RUN);

endmodule

// File: tb/tb_i2c_phase_timer.sv
// Bench for i2c_phase_timer: expected pulses are derived from Ticks/Mode arithmetic and queued at Start.
module tb_i2c_phase_timer;

  localparam int SIZE = 8;
  localparam int PH   = 4;

  logic            Clk;
  logic            Rst_n;
  logic            Start;
  logic            Stop;
  logic [SIZE-1:0] Ticks;
  logic            Mode;
  logic            Out;
  logic [1:0]      Phase;
  logic            BitDone;
  logic            Busy;
`ifdef I2C_PHASE_STRETCH_EN
  logic            Stretch;
`endif

  i2c_phase_timer #(.SIZE(SIZE), .PHASES(PH)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Stop    (Stop),
    .Ticks   (Ticks),
    .Mode    (Mode),
`ifdef I2C_PHASE_STRETCH_EN
    .Stretch (Stretch),
`endif
    .Out     (Out),
    .Phase   (Phase),
    .BitDone (BitDone),
    .Busy    (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int edge_no;
    int ph;
    int bd;
  } ev_t;

  typedef struct {
    int ticks;
    int mode;
    int cycles;
    int exp_pulses;
    int exp_busy;
    int exp_phase;
  } vec_t;

  ev_t  sbq[$];
  vec_t vecs[6];
  int   edge_n;
  int   passed;
  int   total;
  int   pulses;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
  endtask

  task automatic push_ev(input int e, input int ph, input int bd);
    ev_t ev;
    ev.edge_no = e;
    ev.ph      = ph;
    ev.bd      = bd;
    sbq.push_back(ev);
  endtask

  // Pulse k lands k*T edges after Start; one-shot stops after PH pulses.
  task automatic push_formula(input int t, input int m, input int cycles);
    if (t == 0) return;
    for (int k = 1; k * t <= cycles; k++) begin
      if (m != 0 && k > PH) break;
      push_ev(k * t, k % PH, (k % PH == 0) ? 1 : 0);
    end
  endtask

  task automatic check_cycle();
    ev_t ev;
    if (sbq.size() > 0 && sbq[0].edge_no == edge_n) begin
      ev = sbq.pop_front();
      chk("out_pulse", int'(Out), 1);
      chk("out_phase", int'(Phase), ev.ph);
      chk("out_bitdone", int'(BitDone), ev.bd);
    end else begin
      chk("out_quiet", int'(Out), 0);
      chk("bitdone_quiet", int'(BitDone), 0);
    end
    if (Out) pulses++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    edge_n++;
    check_cycle();
  endtask

  task automatic do_start(input int t, input int m);
    sbq.delete();
    pulses = 0;
    Ticks  = SIZE'(t);
    Mode   = m[0];
    Start  = 1'b1;
    edge_n = -1;
    tick();
    Start  = 1'b0;
  endtask

  task automatic run_to(input int last_edge);
    while (edge_n < last_edge) tick();
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    pulses  = 0;
    edge_n  = 0;
    Rst_n   = 1'b0;
    Start   = 1'b0;
    Stop    = 1'b0;
    Ticks   = '0;
    Mode    = 1'b0;
`ifdef I2C_PHASE_STRETCH_EN
    Stretch = 1'b0;
`endif

    vecs[0] = '{ticks: 5, mode: 0, cycles: 41, exp_pulses: 8,  exp_busy: 1, exp_phase: 0};
    vecs[1] = '{ticks: 3, mode: 1, cycles: 20, exp_pulses: 4,  exp_busy: 0, exp_phase: 0};
    vecs[2] = '{ticks: 1, mode: 0, cycles: 10, exp_pulses: 10, exp_busy: 1, exp_phase: 2};
    vecs[3] = '{ticks: 0, mode: 0, cycles: 50, exp_pulses: 0,  exp_busy: 0, exp_phase: 0};
    vecs[4] = '{ticks: 7, mode: 1, cycles: 40, exp_pulses: 4,  exp_busy: 0, exp_phase: 0};
    vecs[5] = '{ticks: 2, mode: 0, cycles: 9,  exp_pulses: 4,  exp_busy: 1, exp_phase: 0};

    #2;
    chk("rst_out", int'(Out), 0);
    chk("rst_phase", int'(Phase), 0);
    chk("rst_bitdone", int'(BitDone), 0);
    chk("rst_busy", int'(Busy), 0);
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(Busy), 0);

    // Table-driven runs; Ticks/Mode are scrambled mid-run and must be ignored.
    for (int v = 0; v < 6; v++) begin
      int ph_exp;
      int busy_exp;
      do_start(vecs[v].ticks, vecs[v].mode);
      push_formula(vecs[v].ticks, vecs[v].mode, vecs[v].cycles);
      while (edge_n < vecs[v].cycles) begin
        Ticks = SIZE'($urandom_range(0, 255));
        Mode  = 1'($urandom_range(0, 1));
        if (vecs[v].ticks == 0) begin
          busy_exp = 0;
          ph_exp   = 0;
        end else if (vecs[v].mode != 0 && edge_n >= PH * vecs[v].ticks) begin
          busy_exp = 0;
          ph_exp   = 0;
        end else begin
          busy_exp = 1;
          ph_exp   = (edge_n / vecs[v].ticks) % PH;
        end
        chk("busy_trace", int'(Busy), busy_exp);
        chk("phase_trace", int'(Phase), ph_exp);
        tick();
      end
      chk("vec_pulses", pulses, vecs[v].exp_pulses);
      chk("vec_busy", int'(Busy), vecs[v].exp_busy);
      chk("vec_phase", int'(Phase), vecs[v].exp_phase);
      chk("vec_queue_empty", sbq.size(), 0);
    end

    // Stop for 8 cycles once cnt has reached 4 delays the first pulse by 8.
    do_start(8, 0);
    push_ev(16, 1, 0);
    push_ev(24, 2, 0);
    run_to(4);
    Stop = 1'b1;
    run_to(12);
    chk("stop_busy_hold", int'(Busy), 1);
    chk("stop_phase_hold", int'(Phase), 0);
    Stop = 1'b0;
    run_to(30);
    chk("stop_queue_empty", sbq.size(), 0);

    // Start wins over Stop: load happens, then the count holds while Stop stays high.
    Stop = 1'b1;
    do_start(2, 0);
    chk("startstop_busy", int'(Busy), 1);
    push_ev(5, 1, 0);
    push_ev(7, 2, 0);
    run_to(3);
    Stop = 1'b0;
    run_to(8);
    chk("startstop_queue_empty", sbq.size(), 0);

    // Restart mid-phase with a shorter Ticks.
    do_start(10, 0);
    run_to(6);
    do_start(2, 0);
    chk("restart_phase", int'(Phase), 0);
    push_ev(2, 1, 0);
    push_ev(4, 2, 0);
    run_to(5);
    chk("restart_queue_empty", sbq.size(), 0);

    // Asynchronous reset in phase 2, then silence until a new Start.
    do_start(4, 0);
    push_formula(4, 0, 8);
    run_to(9);
    chk("pre_rst_phase", int'(Phase), 2);
    sbq.delete();
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_out", int'(Out), 0);
    chk("arst_phase", int'(Phase), 0);
    chk("arst_bitdone", int'(BitDone), 0);
    chk("arst_busy", int'(Busy), 0);
    tick();
    tick();
    Rst_n  = 1'b1;
    pulses = 0;
    repeat (30) tick();
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_busy", int'(Busy), 0);

`ifdef I2C_PHASE_STRETCH_EN
    // Stretch held for 6 cycles at the phase-2 terminal count.
    do_start(3, 0);
    push_ev(3, 1, 0);
    push_ev(6, 2, 0);
    push_ev(15, 3, 0);
    push_ev(18, 0, 1);
    run_to(8);
    Stretch = 1'b1;
    run_to(14);
    chk("stretch_phase_hold", int'(Phase), 2);
    Stretch = 1'b0;
    run_to(20);
    chk("stretch_queue_empty", sbq.size(), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
